// File: rtl/tetron_cell_sequencer.sv
// Sequences the four absolute board cells of any tetromino placement, one per
// handshake, flagging cells outside the ROWS x COLS board.
module tetron_cell_sequencer #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int CW   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_piece,
  input  logic [1:0]    req_rot,
  input  logic [CW-1:0] req_row,
  input  logic [CW-1:0] req_col,
  output logic          cell_valid,
  input  logic          cell_ready,
  output logic [1:0]    cell_idx,
  output logic [CW-1:0] cell_row,
  output logic [CW-1:0] cell_col,
  output logic          cell_oob,
  output logic          done,
  output logic          done_oob,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  typedef struct packed {
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          oob;
  } cell_t;

  localparam logic signed [2:0]  Z0 = 3'sd0;
  localparam logic signed [2:0]  P1 = 3'sd1;
  localparam logic signed [2:0]  P2 = 3'sd2;
  localparam logic signed [2:0]  N1 = -3'sd1;
  localparam logic signed [CW:0] ROWS_S = (CW+1)'(ROWS);
  localparam logic signed [CW:0] COLS_S = (CW+1)'(COLS);

  function automatic cell_t calc(input logic [2:0] piece, input logic [1:0] rot,
                                 input logic [CW-1:0] row, input logic [CW-1:0] col,
                                 input logic [1:0] idx);
    logic signed [2:0]  v, h, rv, rh;
    logic signed [CW:0] sr, sc;
    logic [1:0]         r;
    cell_t              c;
    v = Z0;
    h = Z0;
    case ({piece, idx})
      5'b000_01: begin v = Z0; h = N1; end
      5'b000_10: begin v = Z0; h = P1; end
      5'b000_11: begin v = Z0; h = P2; end
      5'b001_01: begin v = Z0; h = P1; end
      5'b001_10: begin v = P1; h = Z0; end
      5'b001_11: begin v = P1; h = P1; end
      5'b010_01: begin v = Z0; h = N1; end
      5'b010_10: begin v = Z0; h = P1; end
      5'b010_11: begin v = P1; h = Z0; end
      5'b011_01: begin v = Z0; h = P1; end
      5'b011_10: begin v = P1; h = N1; end
      5'b011_11: begin v = P1; h = Z0; end
      5'b100_01: begin v = Z0; h = N1; end
      5'b100_10: begin v = P1; h = Z0; end
      5'b100_11: begin v = P1; h = P1; end
      5'b101_01: begin v = Z0; h = N1; end
      5'b101_10: begin v = Z0; h = P1; end
      5'b101_11: begin v = P1; h = P1; end
      5'b110_01: begin v = Z0; h = P1; end
      5'b110_10: begin v = Z0; h = N1; end
      5'b110_11: begin v = P1; h = N1; end
      default:   begin v = Z0; h = Z0; end
    endcase
    // The O piece is rotation-symmetric about its own anchor convention.
    r = (piece == 3'd1) ? 2'd0 : rot;
    case (r)
      2'd1:    begin rv = h;  rh = -v; end
      2'd2:    begin rv = -v; rh = -h; end
      2'd3:    begin rv = -h; rh = v;  end
      default: begin rv = v;  rh = h;  end
    endcase
    sr = $signed({1'b0, row}) + $signed({{(CW-2){rv[2]}}, rv});
    sc = $signed({1'b0, col}) + $signed({{(CW-2){rh[2]}}, rh});
    c.row = sr[CW-1:0];
    c.col = sc[CW-1:0];
    c.oob = sr[CW] | (sr >= ROWS_S) | sc[CW] | (sc >= COLS_S);
    return c;
  endfunction

  state_t        state;
  logic [2:0]    piece_q;
  logic [1:0]    rot_q;
  logic [CW-1:0] row_q, col_q;
  logic          acc;
  logic [1:0]    nidx;
  cell_t         first_cell, next_cell;

  assign nidx       = cell_idx + 2'd1;
  assign first_cell = calc(req_piece, req_rot, req_row, req_col, 2'd0);
  assign next_cell  = calc(piece_q, rot_q, row_q, col_q, nidx);
  assign req_ready  = rst_n && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      piece_q    <= '0;
      rot_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      acc        <= 1'b0;
      cell_valid <= 1'b0;
      cell_idx   <= '0;
      cell_row   <= '0;
      cell_col   <= '0;
      cell_oob   <= 1'b0;
      done       <= 1'b0;
      done_oob   <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          done_oob <= 1'b0;
          if (req_valid) begin
            if (req_piece == 3'd7) begin
              err <= 1'b1;
            end else begin
              piece_q    <= req_piece;
              rot_q      <= req_rot;
              row_q      <= req_row;
              col_q      <= req_col;
              state      <= EMIT;
              cell_valid <= 1'b1;
              cell_idx   <= 2'd0;
              {cell_row, cell_col, cell_oob} <= first_cell;
            end
          end
        end
        EMIT: begin
          if (cell_ready) begin
            acc <= acc | cell_oob;
            if (cell_idx == 2'd3) begin
              state      <= DONE;
              cell_valid <= 1'b0;
              done       <= 1'b1;
              done_oob   <= acc | cell_oob;
            end else begin
              cell_idx <= nidx;
              {cell_row, cell_col, cell_oob} <= next_cell;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          acc      <= 1'b0;
          done_oob <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tetron_cell_sequencer.sv
// Scoreboard bench for tetron_cell_sequencer: expected cells are queued per
// request, observed cells are captured per cycle and compared in order.
module tb_tetron_cell_sequencer;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [2:0]    req_piece = '0;
  logic [1:0]    req_rot = '0;
  logic [CW-1:0] req_row = '0, req_col = '0;
  logic          cell_ready = 1'b0;
  logic          req_ready, cell_valid, cell_oob, done, done_oob, err;
  logic [1:0]    cell_idx;
  logic [CW-1:0] cell_row, cell_col;

  tetron_cell_sequencer #(.ROWS(20), .COLS(10), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_piece(req_piece), .req_rot(req_rot), .req_row(req_row), .req_col(req_col),
    .cell_valid(cell_valid), .cell_ready(cell_ready), .cell_idx(cell_idx),
    .cell_row(cell_row), .cell_col(cell_col), .cell_oob(cell_oob),
    .done(done), .done_oob(done_oob), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    idx;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          oob;
  } cell_s;

  cell_s exp_q[$], obs_q[$];
  int    n_cmp = 0, n_bad = 0;
  int    done_cyc;
  logic  done_oob_seen, rr_after, glitch_seen;

  task automatic push(input int i, input int r, input int c, input bit o);
    exp_q.push_back({2'(i), CW'(r), CW'(c), o});
  endtask

  // Present a request for one edge, then scramble the request fields.
  task automatic issue(input int p, input int rot, input int r, input int c);
    req_valid = 1'b1;
    req_piece = 3'(p);
    req_rot   = 2'(rot);
    req_row   = CW'(r);
    req_col   = CW'(c);
    @(negedge clk);
    req_valid = 1'b0;
    req_piece = 3'($urandom);
    req_rot   = 2'($urandom);
    req_row   = CW'($urandom);
    req_col   = CW'($urandom);
  endtask

  // Capture every visible cell (stalled cycles included) until done.
  task automatic collect(input int stall_at, input int stall_n);
    int left;
    left = stall_n;
    done_cyc = -1; done_oob_seen = 1'b0; rr_after = 1'b0; glitch_seen = 1'b0;
    obs_q.delete();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (err) glitch_seen = 1'b1;
      if (done) begin
        done_cyc = cyc;
        done_oob_seen = done_oob;
        if (cell_valid) glitch_seen = 1'b1;
        @(negedge clk);
        rr_after = req_ready;
        return;
      end
      if (cell_valid) begin
        obs_q.push_back({cell_idx, cell_row, cell_col, cell_oob});
        if (cell_idx == 2'(stall_at) && left > 0) begin
          cell_ready = 1'b0;
          left--;
        end else cell_ready = 1'b1;
      end else cell_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cell_valid, done, done_oob, err, cell_idx, cell_row, cell_col, req_ready} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: valid=%b done=%b doob=%b err=%b idx=%0d row=%0d col=%0d rdy=%b required all 0",
               cell_valid, done, done_oob, err, cell_idx, cell_row, cell_col, req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_rot0();
    cell_s e, o;
    push(0, 5, 4, 0); push(1, 5, 5, 0); push(2, 5, 3, 0); push(3, 6, 3, 0);
    issue(6, 0, 5, 4);
    collect(0, 0);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL rot0_count: got %0d cells required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL rot0_cell: got %h required %h", o, e);
      end
    end
    exp_q.delete();
    n_cmp++;
    if (done_cyc != 5 || done_oob_seen !== 1'b0 || rr_after !== 1'b1 || glitch_seen) begin
      n_bad++;
      $display("FAIL rot0_done: cyc=%0d doob=%b rdy=%b glitch=%b required cyc=5 doob=0 rdy=1 glitch=0",
               done_cyc, done_oob_seen, rr_after, glitch_seen);
    end
  endtask

  task automatic test_row_bounds();
    cell_s e, o;
    push(0, 0, 4, 0); push(1, 1, 4, 0); push(2, -1, 4, 1); push(3, -1, 3, 1);
    issue(6, 1, 0, 4);
    collect(0, 0);
    push(0, 18, 0, 0); push(1, 17, 0, 0); push(2, 19, 0, 0); push(3, 20, 0, 1);
    n_cmp++;
    if (done_cyc != 5 || done_oob_seen !== 1'b1) begin
      n_bad++; $display("FAIL lrot1_done: cyc=%0d doob=%b required cyc=5 doob=1", done_cyc, done_oob_seen);
    end
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL lrot1_cell: got none required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++; $display("FAIL lrot1_cell: got %h required %h", o, e);
        end
      end
    end
    issue(0, 1, 18, 0);
    collect(0, 0);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL irot1_count: got %0d cells required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL irot1_cell: got %h required %h", o, e);
      end
    end
    exp_q.delete();
    n_cmp++;
    if (done_cyc != 5 || done_oob_seen !== 1'b1) begin
      n_bad++; $display("FAIL irot1_done: cyc=%0d doob=%b required cyc=5 doob=1", done_cyc, done_oob_seen);
    end
  endtask

  task automatic test_col_bounds();
    cell_s e, o;
    // Z rot3 near the right edge, then L rot0 at the left edge.
    push(0, 10, 9, 0); push(1, 11, 9, 0); push(2, 10, 10, 1); push(3, 9, 10, 1);
    push(0, 0, 0, 0);  push(1, 0, 1, 0);   push(2, 0, -1, 1);  push(3, 1, -1, 1);
    issue(4, 3, 10, 9);
    collect(0, 0);
    n_cmp++;
    if (done_cyc != 5 || done_oob_seen !== 1'b1) begin
      n_bad++; $display("FAIL zrot3_done: cyc=%0d doob=%b required cyc=5 doob=1", done_cyc, done_oob_seen);
    end
    issue(6, 0, 0, 0);
    collect(0, 0);
    n_cmp++;
    if (done_cyc != 5 || done_oob_seen !== 1'b1) begin
      n_bad++; $display("FAIL lleft_done: cyc=%0d doob=%b required cyc=5 doob=1", done_cyc, done_oob_seen);
    end
    // The first piece's cells were overwritten by the second collect; check the second.
    for (int k = 0; k < 4; k++) void'(exp_q.pop_front());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL lleft_cell: got %h required %h", o, e);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_bad++; $display("FAIL lleft_count: leftover exp=%0d obs=%0d required 0", exp_q.size(), obs_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    cell_s e, o;
    push(0, 3, 3, 0);
    repeat (4) push(1, 3, 2, 0);
    push(2, 3, 4, 0); push(3, 4, 3, 0);
    issue(2, 0, 3, 3);
    collect(1, 3);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL bp_count: got %0d samples required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL bp_cell: got %h required %h", o, e);
      end
    end
    exp_q.delete();
    n_cmp++;
    if (done_cyc != 8 || done_oob_seen !== 1'b0 || glitch_seen) begin
      n_bad++; $display("FAIL bp_done: cyc=%0d doob=%b glitch=%b required cyc=8 doob=0 glitch=0",
                        done_cyc, done_oob_seen, glitch_seen);
    end
  endtask

  task automatic test_invalid();
    cell_s e, o;
    issue(7, 0, 4, 4);
    n_cmp++;
    if (err !== 1'b1 || cell_valid !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL invalid_err: err=%b valid=%b done=%b rdy=%b required err=1 valid=0 done=0 rdy=1",
                        err, cell_valid, done, req_ready);
    end
    push(0, 10, 5, 0); push(1, 10, 6, 0); push(2, 11, 5, 0); push(3, 11, 6, 0);
    issue(1, 2, 10, 5);
    collect(0, 0);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL after_invalid_count: got %0d cells required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL after_invalid_cell: got %h required %h", o, e);
      end
    end
    exp_q.delete();
    n_cmp++;
    if (done_cyc != 5 || glitch_seen) begin
      n_bad++; $display("FAIL after_invalid_done: cyc=%0d glitch=%b required cyc=5 glitch=0", done_cyc, glitch_seen);
    end
  endtask

  task automatic test_reset_mid();
    cell_s e, o;
    issue(6, 0, 5, 4);
    cell_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (cell_valid !== 1'b1 || cell_idx !== 2'd2) begin
      n_bad++; $display("FAIL mid_pre: valid=%b idx=%0d required valid=1 idx=2", cell_valid, cell_idx);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cell_valid, done, cell_idx, cell_row, cell_col, req_ready} !== '0) begin
      n_bad++; $display("FAIL mid_reset: valid=%b done=%b idx=%0d row=%0d col=%0d rdy=%b required all 0",
                        cell_valid, done, cell_idx, cell_row, cell_col, req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL mid_release: rdy=%b done=%b required rdy=1 done=0", req_ready, done);
    end
    push(0, 2, 2, 0); push(1, 2, 1, 0); push(2, 2, 3, 0); push(3, 3, 3, 0);
    issue(5, 0, 2, 2);
    collect(0, 0);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL restart_count: got %0d cells required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL restart_cell: got %h required %h", o, e);
      end
    end
    exp_q.delete();
    n_cmp++;
    if (done_cyc != 5 || done_oob_seen !== 1'b0) begin
      n_bad++; $display("FAIL restart_done: cyc=%0d doob=%b required cyc=5 doob=0", done_cyc, done_oob_seen);
    end
  endtask

  initial begin
    test_reset();
    test_rot0();
    test_row_bounds();
    test_col_bounds();
    test_backpressure();
    test_invalid();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
